// File: rtl/mesh_inlet_sequencer_pkg.sv
// rtl/mesh_inlet_sequencer_pkg.sv - shared types, timing defaults and round-robin search for the mesh inlet sequencer
// Package mesh_seq_pkg:
//   state_e      run-sequencer states
//   *_DEF        default timing/size constants
//   next_masked  first set mask bit at or after ptr, wrapping at n-1 -> 0
package mesh_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SETTLE,
        SAMPLE,
        FLUSH
    } state_e;

    localparam int N_INLETS_DEF       = 8;
    localparam int MESH_DEPTH_DEF     = 3;
    localparam int SETTLE_PER_STG_DEF = 64;
    localparam int FILL_W_DEF         = 16;
    localparam int FLUSH_CYC_DEF      = 128;

    // Upper bound on inlet count handled by the search function.
    localparam int MAX_INLETS = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // Scan offsets 0..n-1 from ptr; the lowest offset with a set bit wins.
    // ptr is assumed < n, so a single subtraction is enough to wrap.
    function automatic pick_t next_masked(input logic [MAX_INLETS-1:0] mask,
                                          input logic [4:0]            ptr,
                                          input int                    n);
        pick_t      r;
        logic [5:0] cand;
        r.found = 1'b0;
        r.idx   = '0;
        for (int off = 0; off < MAX_INLETS; off++) begin
            cand = {1'b0, ptr} + 6'(off);
            if (cand >= 6'(n)) begin
                cand = cand - 6'(n);
            end
            if ((off < n) && !r.found && mask[cand[4:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[4:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mesh_inlet_sequencer_if.sv
// rtl/mesh_inlet_sequencer_if.sv - run-control / valve-drive signal bundle of the mesh inlet sequencer
// Interface mesh_seq_if:
//   run control : start, abort, inlet_mask, fill_cycles, sample_ready   (master -> slave)
//   drive/status: valve_open, pump_on, cur_inlet, busy, sample_valid,
//                 done, err_empty                                      (slave -> master)
//   modport master: run-control side; modport slave: the sequencer.
interface mesh_seq_if
    import mesh_seq_pkg::*;
#(
    parameter int N_INLETS = N_INLETS_DEF,
    parameter int FILL_W   = FILL_W_DEF
);
    localparam int IW = $clog2(N_INLETS);

    logic                start;
    logic                abort;
    logic [N_INLETS-1:0] inlet_mask;
    logic [FILL_W-1:0]   fill_cycles;
    logic                sample_ready;

    logic [N_INLETS-1:0] valve_open;
    logic                pump_on;
    logic [IW-1:0]       cur_inlet;
    logic                busy;
    logic                sample_valid;
    logic                done;
    logic                err_empty;

    modport master (
        output start, abort, inlet_mask, fill_cycles, sample_ready,
        input  valve_open, pump_on, cur_inlet, busy, sample_valid, done, err_empty
    );

    modport slave (
        input  start, abort, inlet_mask, fill_cycles, sample_ready,
        output valve_open, pump_on, cur_inlet, busy, sample_valid, done, err_empty
    );

endinterface

// File: rtl/mesh_inlet_sequencer_rr_picker.sv
// rtl/mesh_inlet_sequencer_rr_picker.sv - combinational round-robin inlet pick
// Module mesh_rr_picker:
//   mask_i   inlets still eligible
//   ptr_i    search start position
//   found_o  some eligible inlet exists
//   idx_o    first eligible inlet at or after ptr_i (wrapping)
module mesh_rr_picker
    import mesh_seq_pkg::*;
#(
    parameter  int N_INLETS = N_INLETS_DEF,
    localparam int IW       = $clog2(N_INLETS)
) (
    input  logic [N_INLETS-1:0] mask_i,
    input  logic [IW-1:0]       ptr_i,
    output logic                found_o,
    output logic [IW-1:0]       idx_o
);

    pick_t pick;

    always_comb begin
        pick    = next_masked(MAX_INLETS'(mask_i), 5'(ptr_i), N_INLETS);
        found_o = pick.found;
        idx_o   = IW'(pick.idx);
    end

endmodule

// File: rtl/mesh_inlet_sequencer.sv
// rtl/mesh_inlet_sequencer.sv - shared-pump round-robin inlet fill, settle, sample and flush sequencer
// Module mesh_inlet_sequencer (optional flush phase enabled by defining MESH_FLUSH_EN):
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    mesh_seq_if.slave: run control in; valve/pump drive and status out
// All outputs are registered; each *_d below is the value the output takes next cycle.
module mesh_inlet_sequencer
    import mesh_seq_pkg::*;
#(
    parameter int N_INLETS       = N_INLETS_DEF,
    parameter int MESH_DEPTH     = MESH_DEPTH_DEF,
    parameter int SETTLE_PER_STG = SETTLE_PER_STG_DEF,
    parameter int FILL_W         = FILL_W_DEF,
    parameter int FLUSH_CYC      = FLUSH_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    mesh_seq_if.slave  bus
);

    localparam int IW         = $clog2(N_INLETS);
    localparam int SETTLE_CYC = MESH_DEPTH * SETTLE_PER_STG;
    localparam int CW_A       = (FILL_W > $clog2(SETTLE_CYC + 1)) ? FILL_W : $clog2(SETTLE_CYC + 1);
    localparam int CNT_W      = (CW_A > $clog2(FLUSH_CYC + 1)) ? CW_A : $clog2(FLUSH_CYC + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_INLETS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_INLETS-1:0] mask_rem_q, mask_rem_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                gap_q, gap_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       cur_q, cur_d;
    logic [N_INLETS-1:0] valve_q, valve_d;
    logic                pump_q, pump_d;
    logic                busy_q, busy_d;
    logic                sv_q, sv_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [IW-1:0]       cur_next;
    logic [N_INLETS-1:0] pick_mask;
    logic [IW-1:0]       pick_ptr;
    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic [N_INLETS-1:0] pick_onehot;
    logic [CNT_W-1:0]    fill_eff;
    logic [CNT_W-1:0]    cnt_inc;

    assign cur_next = (cur_q == LAST_IDX) ? '0 : cur_q + IW'(1);

    // In IDLE the pick chooses the first inlet of the new run; inside FILL it
    // looks for the next inlet still owed service, starting after the current one.
    assign pick_mask = (state_q == IDLE) ? bus.inlet_mask : mask_rem_q;
    assign pick_ptr  = (state_q == IDLE) ? rr_ptr_q : cur_next;

    mesh_rr_picker #(.N_INLETS(N_INLETS)) u_picker (
        .mask_i  (pick_mask),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign pick_onehot = N_INLETS'(1) << pick_idx;
    assign fill_eff    = (fill_q == '0) ? CNT_W'(1) : CNT_W'(fill_q);
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        mask_rem_d = mask_rem_q;
        fill_d     = fill_q;
        gap_d      = gap_q;
        rr_ptr_d   = rr_ptr_q;
        cur_d      = cur_q;
        valve_d    = valve_q;
        pump_d     = pump_q;
        sv_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                valve_d = '0;
                pump_d  = 1'b0;
                if (bus.start) begin
                    if (pick_found) begin
                        state_d    = FILL;
                        fill_d     = bus.fill_cycles;
                        mask_rem_d = bus.inlet_mask & ~pick_onehot;
                        cur_d      = pick_idx;
                        valve_d    = pick_onehot;
                        pump_d     = 1'b1;
                        cnt_d      = CNT_W'(1);
                        gap_d      = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            FILL: begin
                if (bus.abort) begin
                    valve_d = '0;
                    gap_d   = 1'b0;
                    pump_d  = 1'b0;
`ifdef MESH_FLUSH_EN
                    state_d = FLUSH;
                    cnt_d   = '0;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else if (gap_q) begin
                    // Break-before-make cycle is over: open the next inlet.
                    gap_d      = 1'b0;
                    cur_d      = pick_idx;
                    mask_rem_d = mask_rem_q & ~pick_onehot;
                    valve_d    = pick_onehot;
                    cnt_d      = CNT_W'(1);
                end else if (cnt_q >= fill_eff) begin
                    valve_d = '0;
                    if (pick_found) begin
                        gap_d = 1'b1;
                    end else begin
                        state_d  = SETTLE;
                        pump_d   = 1'b0;
                        rr_ptr_d = cur_next;
                        cnt_d    = CNT_W'(1);
                    end
                end
            end

            SETTLE: begin
                if (bus.abort) begin
                    valve_d = '0;
                    pump_d  = 1'b0;
`ifdef MESH_FLUSH_EN
                    state_d = FLUSH;
                    cnt_d   = '0;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else if (cnt_q >= CNT_W'(SETTLE_CYC)) begin
                    state_d = SAMPLE;
                    sv_d    = 1'b1;
                end
            end

            SAMPLE: begin
                sv_d = 1'b1;
                if (bus.abort) begin
                    sv_d    = 1'b0;
                    valve_d = '0;
                    pump_d  = 1'b0;
`ifdef MESH_FLUSH_EN
                    state_d = FLUSH;
                    cnt_d   = '0;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else if (bus.sample_ready) begin
                    sv_d = 1'b0;
`ifdef MESH_FLUSH_EN
                    state_d = FLUSH;
                    valve_d = '1;
                    pump_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end

`ifdef MESH_FLUSH_EN
            FLUSH: begin
                // cnt_q==0 only after an abort: one closed-valve cycle before flushing.
                if (cnt_q == '0) begin
                    valve_d = '1;
                    pump_d  = 1'b1;
                end else if (cnt_q >= CNT_W'(FLUSH_CYC)) begin
                    state_d = IDLE;
                    valve_d = '0;
                    pump_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif

            default: begin
                state_d = IDLE;
                valve_d = '0;
                pump_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mask_rem_q <= '0;
            fill_q     <= '0;
            gap_q      <= 1'b0;
            rr_ptr_q   <= '0;
            cur_q      <= '0;
            valve_q    <= '0;
            pump_q     <= 1'b0;
            busy_q     <= 1'b0;
            sv_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_rem_q <= mask_rem_d;
            fill_q     <= fill_d;
            gap_q      <= gap_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_q      <= cur_d;
            valve_q    <= valve_d;
            pump_q     <= pump_d;
            busy_q     <= busy_d;
            sv_q       <= sv_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.valve_open   = valve_q;
    assign bus.pump_on      = pump_q;
    assign bus.cur_inlet    = cur_q;
    assign bus.busy         = busy_q;
    assign bus.sample_valid = sv_q;
    assign bus.done         = done_q;
    assign bus.err_empty    = err_q;

endmodule

// File: tb/tb_mesh_inlet_sequencer.sv
// tb/tb_mesh_inlet_sequencer.sv - directed self-checking bench for mesh_inlet_sequencer
module tb_mesh_inlet_sequencer;
    import mesh_seq_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mesh_seq_if #(.N_INLETS(8), .FILL_W(16)) bus ();

    mesh_inlet_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic launch(input logic [7:0] m, input logic [15:0] f);
        bus.inlet_mask  = m;
        bus.fill_cycles = f;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
    endtask

    task automatic wait_sv(input string tag);
        int n = 0;
        while (bus.sample_valid !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check(tag, bus.sample_valid, 1);
    endtask

    task automatic accept_and_finish(input string tag);
        bus.sample_ready = 1'b1;
        step();
        bus.sample_ready = 1'b0;
`ifdef MESH_FLUSH_EN
        begin
            int n = 0;
            while (bus.done !== 1'b1 && n < 300) begin
                step();
                n++;
            end
        end
`endif
        check(tag, bus.done, 1);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.inlet_mask   = '0;
        bus.fill_cycles  = '0;
        bus.sample_ready = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_valve", bus.valve_open, 0);
        check("rst_pump", bus.pump_on, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sv", bus.sample_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err_empty, 0);
        check("rst_cur", bus.cur_inlet, 0);
        rst_n = 1'b1;
        step();

        // 1: mask 0000_0101, fill 4
        launch(8'h05, 16'd4);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("t1_valve_c%0d", c), bus.valve_open, 32'h01);
            check($sformatf("t1_pump_c%0d", c), bus.pump_on, 1);
            step();
        end
        check("t1_gap_valve", bus.valve_open, 0);
        check("t1_gap_pump", bus.pump_on, 1);
        step();
        for (int c = 6; c <= 9; c++) begin
            check($sformatf("t1_valve_c%0d", c), bus.valve_open, 32'h04);
            check($sformatf("t1_cur_c%0d", c), bus.cur_inlet, 2);
            step();
        end
        check("t1_settle_valve", bus.valve_open, 0);
        check("t1_settle_pump", bus.pump_on, 0);
        check("t1_settle_busy", bus.busy, 1);
        repeat (191) step();
        check("t1_sv_c201", bus.sample_valid, 0);
        step();
        check("t1_sv_c202", bus.sample_valid, 1);
        accept_and_finish("t1_done");
        step();
        check("t1_idle_busy", bus.busy, 0);

        // 2: rr carry-over with full mask, then 8'h81 from rr_ptr=1
        launch(8'hFF, 16'd1);
        check("t2a_first_valve", bus.valve_open, 32'h08);
        check("t2a_first_cur", bus.cur_inlet, 3);
        step();
        check("t2a_gap_valve", bus.valve_open, 0);
        check("t2a_gap_pump", bus.pump_on, 1);
        step();
        check("t2a_second_valve", bus.valve_open, 32'h10);
        wait_sv("t2a_sv");
        accept_and_finish("t2a_done");
        step();
        launch(8'hFF, 16'd1);
        check("t2b_first_valve", bus.valve_open, 32'h08);
        wait_sv("t2b_sv");
        accept_and_finish("t2b_done");
        step();
        launch(8'h01, 16'd1);
        check("t2c_valve", bus.valve_open, 32'h01);
        wait_sv("t2c_sv");
        accept_and_finish("t2c_done");
        step();
        launch(8'h81, 16'd1);
        check("t2d_valve_c1", bus.valve_open, 32'h80);
        check("t2d_cur_c1", bus.cur_inlet, 7);
        step();
        check("t2d_gap_valve", bus.valve_open, 0);
        step();
        check("t2d_valve_c3", bus.valve_open, 32'h01);
        check("t2d_cur_c3", bus.cur_inlet, 0);
        step();
        check("t2d_end_valve", bus.valve_open, 0);
        check("t2d_end_pump", bus.pump_on, 0);
        wait_sv("t2d_sv");
        accept_and_finish("t2d_done");
        step();

        // 3: empty mask
        launch(8'h00, 16'd4);
        check("t3_err", bus.err_empty, 1);
        check("t3_busy", bus.busy, 0);
        check("t3_valve", bus.valve_open, 0);
        check("t3_done", bus.done, 0);
        step();
        check("t3_err_pulse", bus.err_empty, 0);
        check("t3_busy2", bus.busy, 0);

        // 4: abort on 3rd FILL cycle (rr_ptr=1 -> inlet 1 first)
        launch(8'h06, 16'd8);
        check("t4_valve_c1", bus.valve_open, 32'h02);
        step();
        step();
        check("t4_valve_c3", bus.valve_open, 32'h02);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t4_abort_valve", bus.valve_open, 0);
        check("t4_abort_sv", bus.sample_valid, 0);
`ifdef MESH_FLUSH_EN
        check("t4_abort_busy", bus.busy, 1);
        step();
        check("t4_flush_first", bus.valve_open, 32'hFF);
        check("t4_flush_pump", bus.pump_on, 1);
        repeat (127) step();
        check("t4_flush_last", bus.valve_open, 32'hFF);
        step();
        check("t4_done", bus.done, 1);
        check("t4_end_valve", bus.valve_open, 0);
`else
        check("t4_done", bus.done, 1);
        check("t4_busy", bus.busy, 0);
`endif
        step();
        check("t4_done_pulse", bus.done, 0);

        // 5: sampler stalls 50 cycles; rr_ptr unchanged by abort -> inlet 1 first
        launch(8'hFF, 16'd1);
        check("t5_first_valve", bus.valve_open, 32'h02);
        check("t5_first_cur", bus.cur_inlet, 1);
        wait_sv("t5_sv");
        for (int i = 0; i < 50; i++) begin
            check($sformatf("t5_hold_%0d", i), bus.sample_valid, 1);
            bus.inlet_mask = 8'h0F;
            bus.start      = (i == 20);
            step();
        end
        bus.start = 1'b0;
        accept_and_finish("t5_done");
        check("t5_sv_drop", bus.sample_valid, 0);
        step();
        check("t5_idle_busy", bus.busy, 0);
        check("t5_idle_valve", bus.valve_open, 0);

        // 6: asynchronous reset mid-FILL
        launch(8'h05, 16'd10);
        check("t6_valve_c1", bus.valve_open, 32'h04);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valve", bus.valve_open, 0);
        check("t6_rst_pump", bus.pump_on, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_cur", bus.cur_inlet, 0);
        step();
        rst_n = 1'b1;
        step();
        launch(8'hFF, 16'd1);
        check("t6_rr_reset_valve", bus.valve_open, 32'h01);
        check("t6_rr_reset_cur", bus.cur_inlet, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
